// File: rtl/dds_pkg.sv
// Shared definitions for the DDS datapath: widths common to the controller
// and the phase-to-amplitude converter, plus the sweep controller state type.
package dds_pkg;

  localparam int PHASE_W = 10;
  localparam int TW_W    = 10;
  localparam int DWELL_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } dds_state_e;

endpackage

// File: rtl/dds_phase_accumulator.sv
// Phase accumulator: adds the tuning word every enabled cycle and wraps
// silently at 2^PHASE_W. Clear has priority over enable.
module dds_phase_accumulator #(
  parameter int PHASE_W = dds_pkg::PHASE_W,
  parameter int TW_W    = dds_pkg::TW_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               clear,
  input  logic               en,
  input  logic [TW_W-1:0]    inc,
  output logic [PHASE_W-1:0] phase
);

  logic [PHASE_W-1:0] inc_ext;

  assign inc_ext = PHASE_W'(inc);

  // Phase register: clear on sweep start, otherwise accumulate modulo 2^PHASE_W.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase <= '0;
    end else if (clear) begin
      phase <= '0;
    end else if (en) begin
      phase <= phase + inc_ext;
    end
  end

endmodule

// File: rtl/dds_sweep_controller.sv
// DDS sweep controller: holds the sweep configuration, runs the
// IDLE/RUN/DONE sequencer and dwell counter, and steps the tuning word that
// feeds the phase accumulator. Outputs are decodes of registers only.
module dds_sweep_controller #(
  parameter int PHASE_W = dds_pkg::PHASE_W,
  parameter int TW_W    = dds_pkg::TW_W,
  parameter int DWELL_W = dds_pkg::DWELL_W
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [TW_W-1:0]    cfg_start_tw,
  input  logic [TW_W-1:0]    cfg_stop_tw,
  input  logic [TW_W-1:0]    cfg_step,
  input  logic [DWELL_W-1:0] cfg_dwell,
  input  logic               cfg_loop,
  input  logic               start,
  input  logic               stop_req,
  output logic [PHASE_W-1:0] phase,
  output logic               phase_valid,
  output logic [TW_W-1:0]    cur_tw,
  output logic               busy,
  output logic               done
);

  import dds_pkg::*;

  dds_state_e         state_q;
  dds_state_e         state_d;

  logic [TW_W-1:0]    start_tw_r;
  logic [TW_W-1:0]    stop_tw_r;
  logic [TW_W-1:0]    step_r;
  logic [DWELL_W-1:0] dwell_r;
  logic               loop_r;

  logic [DWELL_W-1:0] dwell_cnt;
  logic [TW_W:0]      nxt_tw;
  logic               tw_fits;
  logic               dwell_end;
  logic [TW_W-1:0]    start_tw_sel;

  logic               acc_clear;
  logic               acc_en;
  logic               tw_load;
  logic               tw_adv;
  logic               tw_reload;
  logic               dwell_clr;
  logic               dwell_inc;

  // The extra top bit catches the carry so a wrapped word is never played.
  assign nxt_tw       = {1'b0, cur_tw} + {1'b0, step_r};
  assign tw_fits      = !nxt_tw[TW_W] && (nxt_tw[TW_W-1:0] <= stop_tw_r);
  assign dwell_end    = (dwell_cnt == dwell_r);
  // A config written in the same cycle as start is used by that sweep.
  assign start_tw_sel = cfg_valid ? cfg_start_tw : start_tw_r;

  assign cfg_ready   = (state_q == IDLE);
  assign busy        = (state_q == RUN);
  assign phase_valid = (state_q == RUN);
  assign done        = (state_q == DONE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath control decode.
  always_comb begin
    state_d   = state_q;
    acc_clear = 1'b0;
    acc_en    = 1'b0;
    tw_load   = 1'b0;
    tw_adv    = 1'b0;
    tw_reload = 1'b0;
    dwell_clr = 1'b0;
    dwell_inc = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d   = RUN;
          acc_clear = 1'b1;
          tw_load   = 1'b1;
          dwell_clr = 1'b1;
        end
      end
      RUN: begin
        // An abort freezes phase and tuning word and beats a coincident sweep end.
        if (stop_req) begin
          state_d = IDLE;
        end else begin
          acc_en = 1'b1;
          if (dwell_end) begin
            dwell_clr = 1'b1;
            // step = 0 is a fixed tone: the word never advances or ends.
            if (step_r != '0) begin
              if (tw_fits) begin
                tw_adv = 1'b1;
              end else if (loop_r) begin
                tw_reload = 1'b1;
              end else begin
                state_d = DONE;
              end
            end
          end else begin
            dwell_inc = 1'b1;
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Configuration registers, writable only while idle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      start_tw_r <= TW_W'(1);
      stop_tw_r  <= TW_W'(1);
      step_r     <= '0;
      dwell_r    <= '0;
      loop_r     <= 1'b0;
    end else if (cfg_ready && cfg_valid) begin
      start_tw_r <= cfg_start_tw;
      stop_tw_r  <= cfg_stop_tw;
      step_r     <= cfg_step;
      dwell_r    <= cfg_dwell;
      loop_r     <= cfg_loop;
    end
  end

  // Dwell counter: counts RUN cycles spent on the current tuning word.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_cnt <= '0;
    end else if (dwell_clr) begin
      dwell_cnt <= '0;
    end else if (dwell_inc) begin
      dwell_cnt <= dwell_cnt + 1'b1;
    end
  end

  // Tuning word: load on start, then advance or reload at each dwell end.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cur_tw <= '0;
    end else if (tw_load) begin
      cur_tw <= start_tw_sel;
    end else if (tw_adv) begin
      cur_tw <= nxt_tw[TW_W-1:0];
    end else if (tw_reload) begin
      cur_tw <= start_tw_r;
    end
  end

  dds_phase_accumulator #(
    .PHASE_W (PHASE_W),
    .TW_W    (TW_W)
  ) u_phase_acc (
    .clk   (clk),
    .reset (reset),
    .clear (acc_clear),
    .en    (acc_en),
    .inc   (cur_tw),
    .phase (phase)
  );

endmodule

// File: tb/tb_dds_sweep_controller.sv
// Bench for dds_sweep_controller: directed scenarios with literal
// expectations plus randomized traffic, all checked every cycle against a
// sweep model that derives the tuning word from the elapsed RUN cycle count.
module tb_dds_sweep_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [9:0]  cfg_start_tw = '0;
  logic [9:0]  cfg_stop_tw = '0;
  logic [9:0]  cfg_step = '0;
  logic [15:0] cfg_dwell = '0;
  logic        cfg_loop = 1'b0;
  logic        start = 1'b0;
  logic        stop_req = 1'b0;
  logic [9:0]  phase;
  logic        phase_valid;
  logic [9:0]  cur_tw;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;

  dds_sweep_controller dut (
    .clk          (clk),
    .reset        (reset),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_start_tw (cfg_start_tw),
    .cfg_stop_tw  (cfg_stop_tw),
    .cfg_step     (cfg_step),
    .cfg_dwell    (cfg_dwell),
    .cfg_loop     (cfg_loop),
    .start        (start),
    .stop_req     (stop_req),
    .phase        (phase),
    .phase_valid  (phase_valid),
    .cur_tw       (cur_tw),
    .busy         (busy),
    .done         (done)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Model: configuration, sweep word list, elapsed RUN cycles, expected outputs.
  int c_start = 1, c_stop = 1, c_step = 0, c_dwell = 0;
  bit c_loop = 0;
  bit m_run = 0, m_done = 0;
  int m_phase = 0, m_tw = 0, m_k = 0;
  int m_list[$];

  task automatic build_list();
    int w;
    m_list.delete();
    w = c_start;
    m_list.push_back(w);
    if (c_step != 0) begin
      while ((w + c_step <= c_stop) && (w + c_step <= 1023)) begin
        w = w + c_step;
        m_list.push_back(w);
      end
    end
  endtask

  task automatic model_step(input bit r, input bit cv, input int cs, input int cp,
                            input int ct, input int cd, input bit cl,
                            input bit st, input bit sr);
    int idx, n;
    if (r) begin
      m_run = 0; m_done = 0; m_phase = 0; m_tw = 0;
      c_start = 1; c_stop = 1; c_step = 0; c_dwell = 0; c_loop = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (!m_run) begin
      if (cv) begin
        c_start = cs; c_stop = cp; c_step = ct; c_dwell = cd; c_loop = cl;
      end
      if (st) begin
        m_run = 1; m_k = 0; m_phase = 0;
        build_list();
        m_tw = m_list[0];
      end
    end else if (sr) begin
      m_run = 0;
    end else begin
      m_phase = (m_phase + m_tw) % 1024;
      m_k++;
      if (c_step != 0) begin
        idx = m_k / (c_dwell + 1);
        n = m_list.size();
        if (idx < n) m_tw = m_list[idx];
        else if (c_loop) m_tw = m_list[idx % n];
        else begin
          m_run = 0;
          m_done = 1;
        end
      end
    end
  endtask

  // Compare process: sample inputs at the edge, advance the model, check outputs 1 ns later.
  initial begin
    forever begin
      bit s_r, s_cv, s_cl, s_st, s_sr;
      int s_cs, s_cp, s_ct, s_cd;
      @(posedge clk);
      s_r = reset; s_cv = cfg_valid; s_cl = cfg_loop; s_st = start; s_sr = stop_req;
      s_cs = int'(cfg_start_tw); s_cp = int'(cfg_stop_tw);
      s_ct = int'(cfg_step); s_cd = int'(cfg_dwell);
      #1;
      model_step(s_r, s_cv, s_cs, s_cp, s_ct, s_cd, s_cl, s_st, s_sr);
      chk("phase", 32'(phase), 32'(m_phase));
      chk("cur_tw", 32'(cur_tw), 32'(m_tw));
      chk("busy", 32'(busy), 32'(m_run));
      chk("phase_valid", 32'(phase_valid), 32'(m_run));
      chk("done", 32'(done), 32'(m_done));
      chk("cfg_ready", 32'(cfg_ready), 32'(!m_run && !m_done));
    end
  end

  task automatic start_sweep(input int s, input int p, input int t, input int d, input bit l);
    cfg_valid = 1'b1;
    cfg_start_tw = 10'(s); cfg_stop_tw = 10'(p); cfg_step = 10'(t);
    cfg_dwell = 16'(d); cfg_loop = l;
    start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic abort();
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    #1;
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_phase", 32'(phase), 32'd0);
    chk("rst_cur_tw", 32'(cur_tw), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Single sweep 10..30 step 10, dwell 3.
    start_sweep(10, 30, 10, 3, 0);
    chk("ss_c1_tw", 32'(cur_tw), 32'd10);
    chk("ss_c1_phase", 32'(phase), 32'd0);
    chk("ss_c1_busy", 32'(busy), 32'd1);
    repeat (4) @(negedge clk);
    chk("ss_c5_phase", 32'(phase), 32'd40);
    chk("ss_c5_tw", 32'(cur_tw), 32'd20);
    repeat (7) @(negedge clk);
    chk("ss_c12_phase", 32'(phase), 32'd210);
    chk("ss_c12_tw", 32'(cur_tw), 32'd30);
    chk("ss_c12_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("ss_c13_done", 32'(done), 32'd1);
    chk("ss_c13_busy", 32'(busy), 32'd0);
    @(negedge clk);
    chk("ss_c14_done", 32'(done), 32'd0);
    chk("ss_c14_ready", 32'(cfg_ready), 32'd1);

    // Fixed tone with phase wrap.
    start_sweep(1000, 1023, 0, 0, 0);
    chk("ft_p0", 32'(phase), 32'd0);
    @(negedge clk);
    chk("ft_p1", 32'(phase), 32'd1000);
    @(negedge clk);
    chk("ft_p2", 32'(phase), 32'd976);
    @(negedge clk);
    chk("ft_p3", 32'(phase), 32'd952);
    repeat (5000) @(negedge clk);
    chk("ft_busy_5000", 32'(busy), 32'd1);
    chk("ft_tw_5000", 32'(cur_tw), 32'd1000);
    abort();
    chk("ft_abort_busy", 32'(busy), 32'd0);

    // Looping sweep.
    start_sweep(100, 200, 100, 0, 1);
    chk("lp_1", 32'(cur_tw), 32'd100);
    @(negedge clk);
    chk("lp_2", 32'(cur_tw), 32'd200);
    @(negedge clk);
    chk("lp_3", 32'(cur_tw), 32'd100);
    @(negedge clk);
    chk("lp_4", 32'(cur_tw), 32'd200);
    repeat (20) @(negedge clk);
    abort();

    // Carry overflow ends the sweep instead of playing a wrapped word.
    start_sweep(1000, 1023, 100, 2, 0);
    chk("co_1", 32'(cur_tw), 32'd1000);
    repeat (2) @(negedge clk);
    chk("co_3", 32'(cur_tw), 32'd1000);
    chk("co_3_busy", 32'(busy), 32'd1);
    @(negedge clk);
    chk("co_4_done", 32'(done), 32'd1);
    chk("co_4_tw", 32'(cur_tw), 32'd1000);
    @(negedge clk);

    // Abort coinciding with the last RUN cycle.
    start_sweep(10, 30, 10, 3, 0);
    repeat (11) @(negedge clk);
    stop_req = 1'b1;
    @(negedge clk);
    stop_req = 1'b0;
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_done", 32'(done), 32'd0);
    chk("ab_ready", 32'(cfg_ready), 32'd1);
    chk("ab_phase", 32'(phase), 32'd210);
    @(negedge clk);
    chk("ab_done_next", 32'(done), 32'd0);

    // Asynchronous reset between edges, then defaults take effect.
    start_sweep(50, 1023, 0, 0, 0);
    repeat (3) @(negedge clk);
    chk("ar_phase_pre", 32'(phase), 32'd150);
    #2 reset = 1'b1;
    #1;
    chk("ar_phase", 32'(phase), 32'd0);
    chk("ar_tw", 32'(cur_tw), 32'd0);
    chk("ar_busy", 32'(busy), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("ar_default_tw", 32'(cur_tw), 32'd1);
    abort();

    // Config and start in the same cycle.
    start_sweep(55, 100, 5, 1, 0);
    chk("cs_tw", 32'(cur_tw), 32'd55);
    repeat (25) @(negedge clk);

    // Randomized traffic.
    for (int it = 0; it < 30; it++) begin
      int s, p, t, d, sel;
      s = int'($urandom % 1024);
      p = int'($urandom % 1024);
      sel = int'($urandom % 4);
      t = (sel == 0) ? 0 : (sel == 1) ? int'($urandom_range(1, 15)) :
          (sel == 2) ? int'($urandom % 1024) : int'($urandom_range(1, 100));
      d = int'($urandom % 4);
      start_sweep(s, p, t, d, 1'($urandom % 2));
      for (int c = 0; c < 40; c++) begin
        cfg_valid = ($urandom % 4) == 0;
        cfg_start_tw = 10'($urandom);
        cfg_stop_tw = 10'($urandom);
        cfg_step = ($urandom % 2) ? 10'($urandom % 32) : 10'($urandom);
        cfg_dwell = 16'($urandom % 4);
        cfg_loop = 1'($urandom);
        start = ($urandom % 8) == 0;
        stop_req = ($urandom % 32) == 0;
        @(negedge clk);
      end
      cfg_valid = 1'b0;
      start = 1'b0;
      abort();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
